// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : i2c_pkg
//  Description : Shared constants for the I2C byte engines: FSM state codes,
//                bit framing constants and byte-index codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

   // Bit framing: three tick phases per bit, eight data bits plus ACK slot
   localparam int         BIT_PHASES    = 3;
   localparam int         BITS_PER_BYTE = 9;

   // Byte index codes as reported on NACK_BYTE
   localparam logic [1:0] BYTE_ADDR = 2'd0;
   localparam logic [1:0] BYTE_PTR  = 2'd1;
   localparam logic [1:0] BYTE_DATA = 2'd2;
   localparam logic [1:0] NACK_NONE = 2'd3;

   // FSM state encoding (exported on ST for debug)
   localparam int         ST_W     = 5;
   localparam logic [4:0] ST_IDLE  = 5'd0;
   localparam logic [4:0] ST_ARM   = 5'd1;
   localparam logic [4:0] ST_STA_A = 5'd2;
   localparam logic [4:0] ST_STA_B = 5'd3;
   localparam logic [4:0] ST_B_SET = 5'd4;
   localparam logic [4:0] ST_B_HI  = 5'd5;
   localparam logic [4:0] ST_B_LO  = 5'd6;
   localparam logic [4:0] ST_STP_A = 5'd7;
   localparam logic [4:0] ST_STP_B = 5'd8;
   localparam logic [4:0] ST_STP_C = 5'd9;
   localparam logic [4:0] ST_DONE  = 5'd10;

   // Address byte on the wire: 7-bit address with the R/W bit forced to write
   function automatic logic [7:0] write_address(input logic [7:0] addr);
      return {addr[7:1], 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_tx_shift.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_tx_shift
//  Description : 9-bit transmit shift register (data byte followed by a
//                released ACK slot) with a 4-bit count of clocked bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_tx_shift
   import i2c_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic [7:0] i_load_byte,
   input  logic       i_shift,
   input  logic       i_count,
   output logic       o_msb,
   output logic       o_done9
);

   localparam logic [3:0] c_bits_per_byte = 4'(BITS_PER_BYTE);

   logic [8:0] r_shreg;
   logic [3:0] r_bit_cnt;

   // Load a fresh byte with a trailing '1' so the ACK slot releases SDA;
   // shifting fills with '1' for the same reason.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg   <= '1;
         r_bit_cnt <= '0;
      end else if (i_load) begin
         r_shreg   <= {i_load_byte, 1'b1};
         r_bit_cnt <= '0;
      end else begin
         if (i_shift) r_shreg   <= {r_shreg[7:0], 1'b1};
         if (i_count) r_bit_cnt <= r_bit_cnt + 4'd1;
      end
   end

   assign o_msb   = r_shreg[8];
   assign o_done9 = (r_bit_cnt == c_bits_per_byte);

endmodule
`default_nettype wire

// File: rtl/i2c_write_byte.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_write_byte
//  Description : I2C master write engine. Sends START, address+W, optional
//                register pointer, one data byte and STOP on open-drain style
//                SDA/SCL drives (1 = released), three ticks per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_write_byte
   import i2c_pkg::*;
#(
   parameter logic POINTER_EN    = 1'b1,
   parameter logic ABORT_ON_NACK = 1'b1
)(
   input  logic            PT_CK,
   input  logic            RESET_N,
   input  logic [7:0]      SLAVE_ADDRESS,
   input  logic [7:0]      POINTER,
   input  logic [7:0]      WDATA,
   input  logic            GO,
   input  logic            SDAI,
   output logic            SDAO,
   output logic            SCLO,
   output logic            END_OK,
   output logic            ACK_OK,
   output logic [1:0]      NACK_BYTE,
   output logic [ST_W-1:0] ST
);

   logic [ST_W-1:0] r_state;
   logic            r_sdao;
   logic            r_sclo;
   logic            r_end_ok;
   logic            r_ack_ok;
   logic [1:0]      r_nack_byte;
   logic [7:0]      r_addr;
   logic [7:0]      r_ptr;
   logic [7:0]      r_data;
   logic [1:0]      r_byte_idx;
   logic            r_sda_sample;

   logic            w_msb;
   logic            w_done9;
   logic            w_more;
   logic [1:0]      w_next_idx;
   logic [7:0]      w_next_byte;
   logic            w_abort;
   logic            w_advance;
   logic            w_load;
   logic [7:0]      w_load_byte;
   logic            w_shift;
   logic            w_count;

   // Byte sequencing: which byte follows the current one and whether the
   // shift register must be reloaded on this tick.
   always_comb begin
      w_more      = (r_byte_idx != BYTE_DATA);
      w_next_idx  = ((r_byte_idx == BYTE_ADDR) && (POINTER_EN == 1'b1)) ? BYTE_PTR : BYTE_DATA;
      w_next_byte = (w_next_idx == BYTE_PTR) ? r_ptr : r_data;
      w_abort     = r_sda_sample && (ABORT_ON_NACK == 1'b1);
      w_advance   = (r_state == ST_B_LO) && w_done9 && !w_abort && w_more;
      w_load      = (r_state == ST_STA_B) || w_advance;
      w_load_byte = (r_state == ST_STA_B) ? r_addr : w_next_byte;
      w_shift     = (r_state == ST_B_SET);
      w_count     = (r_state == ST_B_HI);
   end

   i2c_tx_shift u_tx_shift (
      .clk         (PT_CK),
      .rst_n       (RESET_N),
      .i_load      (w_load),
      .i_load_byte (w_load_byte),
      .i_shift     (w_shift),
      .i_count     (w_count),
      .o_msb       (w_msb),
      .o_done9     (w_done9)
   );

   // Frame FSM; bus drives are registered and set on entry to each state so
   // SDA only moves on ticks where SCL is held low (bar START/STOP).
   always_ff @(posedge PT_CK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= ST_IDLE;
         r_sdao       <= 1'b1;
         r_sclo       <= 1'b1;
         r_end_ok     <= 1'b1;
         r_ack_ok     <= 1'b0;
         r_nack_byte  <= NACK_NONE;
         r_addr       <= '0;
         r_ptr        <= '0;
         r_data       <= '0;
         r_byte_idx   <= BYTE_ADDR;
         r_sda_sample <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_sdao   <= 1'b1;
               r_sclo   <= 1'b1;
               r_end_ok <= 1'b1;
               if (GO) r_state <= ST_ARM;
            end
            ST_ARM: begin
               if (!GO) begin
                  r_addr      <= write_address(SLAVE_ADDRESS);
                  r_ptr       <= POINTER;
                  r_data      <= WDATA;
                  r_end_ok    <= 1'b0;
                  r_ack_ok    <= 1'b0;
                  r_nack_byte <= NACK_NONE;
                  r_byte_idx  <= BYTE_ADDR;
                  r_sdao      <= 1'b0;
                  r_sclo      <= 1'b1;
                  r_state     <= ST_STA_A;
               end
            end
            ST_STA_A: begin
               r_sclo  <= 1'b0;
               r_state <= ST_STA_B;
            end
            ST_STA_B: begin
               r_sdao  <= r_addr[7];
               r_state <= ST_B_SET;
            end
            ST_B_SET: begin
               r_sclo  <= 1'b1;
               r_state <= ST_B_HI;
            end
            ST_B_HI: begin
               // Only the sample taken on the ACK slot is ever consumed
               r_sda_sample <= SDAI;
               r_sclo       <= 1'b0;
               r_state      <= ST_B_LO;
            end
            ST_B_LO: begin
               if (!w_done9) begin
                  r_sdao  <= w_msb;
                  r_state <= ST_B_SET;
               end else begin
                  if (r_sda_sample && (r_nack_byte == NACK_NONE))
                     r_nack_byte <= r_byte_idx;
                  if (w_advance) begin
                     r_byte_idx <= w_next_idx;
                     r_sdao     <= w_next_byte[7];
                     r_state    <= ST_B_SET;
                  end else begin
                     r_sdao  <= 1'b0;
                     r_state <= ST_STP_A;
                  end
               end
            end
            ST_STP_A: begin
               r_sclo  <= 1'b1;
               r_state <= ST_STP_B;
            end
            ST_STP_B: begin
               r_sdao  <= 1'b1;
               r_state <= ST_STP_C;
            end
            ST_STP_C: begin
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_end_ok <= 1'b1;
               r_ack_ok <= (r_nack_byte == NACK_NONE);
               r_state  <= ST_IDLE;
            end
            default: begin
               r_sdao   <= 1'b1;
               r_sclo   <= 1'b1;
               r_end_ok <= 1'b1;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign SDAO      = r_sdao;
   assign SCLO      = r_sclo;
   assign END_OK    = r_end_ok;
   assign ACK_OK    = r_ack_ok;
   assign NACK_BYTE = r_nack_byte;
   assign ST        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_i2c_write_byte.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_write_byte
//  Description : Self-checking bench for i2c_write_byte. Three instances
//                cover the parameter variants; a bus monitor/slave decodes
//                the frame and a frame-level model predicts bytes, length
//                and status.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_write_byte;

   logic       PT_CK = 1'b0;
   logic       RESET_N;
   logic [7:0] addr, ptr, wdata;
   logic       go;
   logic [1:0] sel;
   logic       sdai_drv;

   logic       sdao   [3];
   logic       sclo   [3];
   logic       end_ok [3];
   logic       ack_ok [3];
   logic [1:0] nack_b [3];
   logic [4:0] st     [3];
   logic       go_v   [3];
   logic       sdai_v [3];

   always #5 PT_CK = ~PT_CK;

   for (genvar k = 0; k < 3; k++) begin : g_route
      assign go_v[k]   = go && (sel == 2'(k));
      assign sdai_v[k] = (sel == 2'(k)) ? sdai_drv : 1'b1;
   end

   i2c_write_byte #(.POINTER_EN(1'b1), .ABORT_ON_NACK(1'b1)) u_dut0 (
      .PT_CK(PT_CK), .RESET_N(RESET_N), .SLAVE_ADDRESS(addr), .POINTER(ptr),
      .WDATA(wdata), .GO(go_v[0]), .SDAI(sdai_v[0]), .SDAO(sdao[0]), .SCLO(sclo[0]),
      .END_OK(end_ok[0]), .ACK_OK(ack_ok[0]), .NACK_BYTE(nack_b[0]), .ST(st[0]));
   i2c_write_byte #(.POINTER_EN(1'b0), .ABORT_ON_NACK(1'b1)) u_dut1 (
      .PT_CK(PT_CK), .RESET_N(RESET_N), .SLAVE_ADDRESS(addr), .POINTER(ptr),
      .WDATA(wdata), .GO(go_v[1]), .SDAI(sdai_v[1]), .SDAO(sdao[1]), .SCLO(sclo[1]),
      .END_OK(end_ok[1]), .ACK_OK(ack_ok[1]), .NACK_BYTE(nack_b[1]), .ST(st[1]));
   i2c_write_byte #(.POINTER_EN(1'b1), .ABORT_ON_NACK(1'b0)) u_dut2 (
      .PT_CK(PT_CK), .RESET_N(RESET_N), .SLAVE_ADDRESS(addr), .POINTER(ptr),
      .WDATA(wdata), .GO(go_v[2]), .SDAI(sdai_v[2]), .SDAO(sdao[2]), .SCLO(sclo[2]),
      .END_OK(end_ok[2]), .ACK_OK(ack_ok[2]), .NACK_BYTE(nack_b[2]), .ST(st[2]));

   logic       m_sda, m_scl, m_end, m_ack;
   logic [1:0] m_nack;
   logic [4:0] m_st;
   assign m_sda  = sdao[sel];
   assign m_scl  = sclo[sel];
   assign m_end  = end_ok[sel];
   assign m_ack  = ack_ok[sel];
   assign m_nack = nack_b[sel];
   assign m_st   = st[sel];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected idle status per instance, plus the status pending for the frame in flight
   bit         exp_ack  [3];
   logic [1:0] exp_nack [3];
   bit         pend_ack;
   logic [1:0] pend_nack;

   // Bus monitor and slave: decode bits on SCL rise, answer ACK slots
   logic       prev_sda = 1'b1, prev_scl = 1'b1;
   int         bitcnt = 0;
   logic [7:0] cur = '0;
   logic [7:0] mon_bytes[$];
   int         n_start = 0, n_stop = 0;
   int         nack_pos = -1;
   bit         mon_en = 1'b0;

   always @(negedge PT_CK) begin
      if (mon_en) begin
         check("bus_sda_scl_same_tick", int'((m_sda ^ prev_sda) & (m_scl ^ prev_scl)), 0);
         if (prev_scl && m_scl && prev_sda && !m_sda) begin
            n_start++;
            bitcnt = 0;
         end else if (prev_scl && m_scl && !prev_sda && m_sda) begin
            n_stop++;
         end else if (!prev_scl && m_scl) begin
            if (bitcnt < 8) begin
               cur = {cur[6:0], m_sda};
               bitcnt++;
               if (bitcnt == 8) mon_bytes.push_back(cur);
            end else begin
               check("ack_slot_released", int'(m_sda), 1);
               sdai_drv = ((mon_bytes.size() - 1) == nack_pos) ? 1'b1 : 1'b0;
               bitcnt = 0;
            end
         end else if (prev_scl && !m_scl) begin
            sdai_drv = 1'b1;
         end
      end
      prev_sda = m_sda;
      prev_scl = m_scl;
   end

   // Measure how long END_OK stays low for each frame
   int low_cnt = 0, last_len = 0, frames_done = 0;
   always @(negedge PT_CK) begin
      if (!m_end) low_cnt++;
      else if (low_cnt > 0) begin
         last_len = low_cnt;
         frames_done++;
         low_cnt = 0;
      end
   end

   // While idle, the bus must be released and status must match the model
   logic prev_end = 1'b1;
   always @(negedge PT_CK) begin
      if (RESET_N && m_end && !prev_end) begin
         exp_ack[sel]  = pend_ack;
         exp_nack[sel] = pend_nack;
      end
      if (RESET_N && mon_en && m_end) begin
         check("idle_sda", int'(m_sda), 1);
         check("idle_scl", int'(m_scl), 1);
         check("idle_ack_ok", int'(m_ack), int'(exp_ack[sel]));
         check("idle_nack_byte", int'(m_nack), int'(exp_nack[sel]));
      end
      prev_end = m_end;
   end

   task automatic launch(input int s, input logic [7:0] a, p, d, input int npos);
      @(negedge PT_CK);
      sel = 2'(s); addr = a; ptr = p; wdata = d;
      mon_bytes.delete();
      n_start = 0; n_stop = 0; nack_pos = npos;
      go = 1'b1;
      @(negedge PT_CK);
      go = 1'b0;
   endtask

   // Frame-level model: byte list, bytes actually sent, END_OK-low length, status
   task automatic run_frame(input string tag, input int s, input logic [7:0] a, p, d,
                            input int npos, input bit pen, input bit abort);
      logic [7:0] exp_q[$];
      int sent, exp_len, f0;
      exp_q.push_back({a[7:1], 1'b0});
      if (pen) exp_q.push_back(p);
      exp_q.push_back(d);
      sent      = (abort && npos >= 0) ? npos + 1 : exp_q.size();
      exp_len   = 2 + 27 * sent + 4;
      pend_ack  = (npos < 0);
      pend_nack = (npos < 0) ? 2'd3 : (npos == 0) ? 2'd0 : (npos == 1 && pen) ? 2'd1 : 2'd2;
      f0 = frames_done;
      launch(s, a, p, d, npos);
      for (int i = 0; i < 400 && frames_done == f0; i++) @(negedge PT_CK);
      check({tag, "_completed"}, int'(frames_done != f0), 1);
      check({tag, "_len"}, last_len, exp_len);
      check({tag, "_nbytes"}, mon_bytes.size(), sent);
      for (int i = 0; i < sent && i < mon_bytes.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), int'(mon_bytes[i]), int'(exp_q[i]));
      check({tag, "_starts"}, n_start, 1);
      check({tag, "_stops"}, n_stop, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_N = 1'b0; go = 1'b0; sel = 2'd0; sdai_drv = 1'b1;
      addr = '0; ptr = '0; wdata = '0;
      pend_ack = 1'b0; pend_nack = 2'd3;
      for (int k = 0; k < 3; k++) begin exp_ack[k] = 1'b0; exp_nack[k] = 2'd3; end
      repeat (3) @(negedge PT_CK);
      RESET_N = 1'b1;
      // Reset state of every instance
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         check("rst_sdao", int'(m_sda), 1);
         check("rst_sclo", int'(m_scl), 1);
         check("rst_end_ok", int'(m_end), 1);
         check("rst_ack_ok", int'(m_ack), 0);
         check("rst_nack_byte", int'(m_nack), 3);
         check("rst_st", int'(m_st), 0);
      end
      sel = 2'd0;
      mon_en = 1'b1;

      // 1: full frame, everything ACKed
      run_frame("t1", 0, 8'h5C, 8'h01, 8'hA5, -1, 1'b1, 1'b1);
      check("t1_len_lit", last_len, 87);
      if (mon_bytes.size() == 3) begin
         check("t1_b0_lit", int'(mon_bytes[0]), 8'h5C);
         check("t1_b1_lit", int'(mon_bytes[1]), 8'h01);
         check("t1_b2_lit", int'(mon_bytes[2]), 8'hA5);
      end
      check("t1_ack_lit", int'(m_ack), 1);
      check("t1_nack_lit", int'(m_nack), 3);

      // 2: no pointer byte
      run_frame("t2", 1, 8'h5C, 8'h01, 8'hA5, -1, 1'b0, 1'b1);
      check("t2_len_lit", last_len, 60);
      if (mon_bytes.size() == 2) check("t2_b1_lit", int'(mon_bytes[1]), 8'hA5);

      // 3: address NACK, abort
      run_frame("t3", 0, 8'h5C, 8'h01, 8'hA5, 0, 1'b1, 1'b1);
      check("t3_len_lit", last_len, 33);
      check("t3_ack_lit", int'(m_ack), 0);
      check("t3_nack_lit", int'(m_nack), 0);

      // 4: pointer NACK, no abort
      run_frame("t4", 2, 8'h5C, 8'h01, 8'hA5, 1, 1'b1, 1'b0);
      check("t4_len_lit", last_len, 87);
      check("t4_nack_lit", int'(m_nack), 1);

      // 5: reset during the data byte
      launch(0, 8'h5C, 8'h01, 8'hA5, -1);
      for (int i = 0; i < 200 && mon_bytes.size() < 2; i++) @(negedge PT_CK);
      check("t5_reached_data", int'(mon_bytes.size() >= 2), 1);
      repeat (10) @(negedge PT_CK);
      mon_en = 1'b0;
      RESET_N = 1'b0;
      #1;
      check("t5_rst_sdao", int'(m_sda), 1);
      check("t5_rst_sclo", int'(m_scl), 1);
      check("t5_rst_end_ok", int'(m_end), 1);
      for (int k = 0; k < 3; k++) begin exp_ack[k] = 1'b0; exp_nack[k] = 2'd3; end
      repeat (2) @(negedge PT_CK);
      RESET_N = 1'b1;
      repeat (2) @(negedge PT_CK);
      sdai_drv = 1'b1; bitcnt = 0;
      mon_en = 1'b1;
      run_frame("t5", 0, 8'hA0, 8'h10, 8'h66, -1, 1'b1, 1'b1);

      // 6: GO re-pulsed and inputs changed mid-frame; address bit0 forced low
      fork
         run_frame("t6", 0, 8'hA3, 8'h22, 8'h3C, -1, 1'b1, 1'b1);
         begin
            repeat (40) @(negedge PT_CK);
            wdata = 8'hFF; addr = 8'h11;
            go = 1'b1;
            repeat (5) @(negedge PT_CK);
            go = 1'b0;
         end
      join
      if (mon_bytes.size() == 3) begin
         check("t6_b0_lit", int'(mon_bytes[0]), 8'hA2);
         check("t6_b2_lit", int'(mon_bytes[2]), 8'h3C);
      end
      repeat (20) @(negedge PT_CK);
      check("t6_no_relaunch", n_start, 1);

      // 7: GO held high keeps the engine armed with the bus released
      n_start = 0;
      go = 1'b1;
      repeat (20) @(negedge PT_CK);
      check("t7_held_end_ok", int'(m_end), 1);
      check("t7_held_no_start", n_start, 0);
      run_frame("t7", 0, 8'h5C, 8'h01, 8'hA5, -1, 1'b1, 1'b1);

      repeat (5) @(negedge PT_CK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
